// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side bundle for the hazard / multdiv controller.
//   Inputs to the controller:  FD/DX instruction words, taken-branch flag,
//                              multdiv unit result handshake.
//   Outputs of the controller: multdiv start pulses, stall/bubble/flush
//                              controls, latched multdiv result and status.
// slave  = the controller itself, master = the pipeline / multdiv side.
interface hazard_ctrl_if;
  logic [31:0] fd_out_ir;
  logic [31:0] dx_out_ir;
  logic        branch_taken;
  logic        data_resultRDY;
  logic [31:0] data_result;
  logic        data_exception;

  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall_fd;
  logic        stall_dx;
  logic        bubble_dx;
  logic        flush_fd;
  logic        md_busy;
  logic [31:0] md_result;
  logic        md_result_valid;
  logic        md_exception;
  logic        md_timeout;

  modport master (
    output fd_out_ir, dx_out_ir, branch_taken,
           data_resultRDY, data_result, data_exception,
    input  ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, flush_fd,
           md_busy, md_result, md_result_valid, md_exception, md_timeout
  );

  modport slave (
    input  fd_out_ir, dx_out_ir, branch_taken,
           data_resultRDY, data_result, data_exception,
    output ctrl_mult, ctrl_div, stall_fd, stall_dx, bubble_dx, flush_fd,
           md_busy, md_result, md_result_valid, md_exception, md_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: resolves the hazards forwarding cannot cover in the 5-stage
// core -- load-use stalls, taken-branch flushes and multi-cycle mul/div
// sequencing (freezes FD/DX until the multdiv unit answers or times out).
// Ports: clock, reset_n (async, active-low), bus (hazard_ctrl_if.slave).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no mul/div in flight; load-use / flush rules active
// S_START | one-cycle ctrl_mult/ctrl_div pulse, FD/DX held, counter cleared
// S_BUSY  | waiting for data_resultRDY or timeout, FD/DX held
// S_DONE  | md_result_valid, stalls released, hazard rules active again
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic         clock,
  input  logic         reset_n,
  hazard_ctrl_if.slave bus
);
  localparam int CW = $clog2(MD_TIMEOUT) + 1;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     res_q, res_d;
  logic            exc_q, exc_d;
  logic            tmo_q, tmo_d;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd, dx_alu;
  assign fd_op  = bus.fd_out_ir[31:27];
  assign fd_rd  = bus.fd_out_ir[26:22];
  assign fd_rs  = bus.fd_out_ir[21:17];
  assign fd_rt  = bus.fd_out_ir[16:12];
  assign dx_op  = bus.dx_out_ir[31:27];
  assign dx_rd  = bus.dx_out_ir[26:22];
  assign dx_alu = bus.dx_out_ir[6:2];

  logic unused_ir_bits;
  assign unused_ir_bits = ^{bus.fd_out_ir[11:0], bus.dx_out_ir[21:7], bus.dx_out_ir[1:0]};

  logic dx_is_mul, dx_is_div, dx_is_md;
  assign dx_is_mul = (dx_op == OP_RTYPE) && (dx_alu == ALU_MUL);
  assign dx_is_div = (dx_op == OP_RTYPE) && (dx_alu == ALU_DIV);
  assign dx_is_md  = dx_is_mul || dx_is_div;

  // Which register fields the FD instruction actually reads.
  logic rs_used, rt_used, rd_used, r30_used;
  always_comb begin
    rs_used  = 1'b0;
    rt_used  = 1'b0;
    rd_used  = 1'b0;
    r30_used = 1'b0;
    case (fd_op)
      OP_RTYPE:                 begin rs_used = 1'b1; rt_used = 1'b1; end
      OP_SW, OP_BNE, OP_BLT:    begin rs_used = 1'b1; rd_used = 1'b1; end
      OP_JR:                    rd_used  = 1'b1;
      OP_BEX:                   r30_used = 1'b1;
      OP_J, OP_JAL, OP_SETX:    ;  // J-type: no register operands
      default:                  rs_used  = 1'b1;
    endcase
  end

  // A store whose only dependence is its data register (rd) is served by
  // the MW->XM memory forward, so it does not stall.
  logic load_use;
  always_comb begin
    load_use = 1'b0;
    if ((dx_op == OP_LW) && (dx_rd != 5'd0)) begin
      load_use = (rs_used  && (fd_rs == dx_rd))
              || (rt_used  && (fd_rt == dx_rd))
              || (r30_used && (dx_rd == 5'd30))
              || (rd_used  && (fd_rd == dx_rd) && (fd_op != OP_SW));
    end
  end

  logic ctrl_mult_c, ctrl_div_c, stall_fd_c, stall_dx_c, bubble_dx_c, flush_fd_c;
  logic md_busy_c, valid_c, hazard_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    exc_d       = exc_q;
    tmo_d       = tmo_q;
    ctrl_mult_c = 1'b0;
    ctrl_div_c  = 1'b0;
    stall_fd_c  = 1'b0;
    stall_dx_c  = 1'b0;
    bubble_dx_c = 1'b0;
    flush_fd_c  = 1'b0;
    md_busy_c   = 1'b0;
    valid_c     = 1'b0;
    hazard_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        hazard_en = 1'b1;
        if (dx_is_md && !bus.branch_taken) state_d = S_START;
      end
      S_START: begin
        ctrl_mult_c = dx_is_mul;
        ctrl_div_c  = dx_is_div;
        stall_fd_c  = 1'b1;
        stall_dx_c  = 1'b1;
        md_busy_c   = 1'b1;
        cnt_d       = '0;
        state_d     = S_BUSY;
      end
      S_BUSY: begin
        stall_fd_c = 1'b1;
        stall_dx_c = 1'b1;
        md_busy_c  = 1'b1;
        cnt_d      = cnt_q + CW'(1);
        if (bus.data_resultRDY) begin
          res_d   = bus.data_result;
          exc_d   = bus.data_exception;
          state_d = S_DONE;
        end else if (cnt_q == CW'(MD_TIMEOUT - 1)) begin
          res_d   = '0;
          exc_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid_c   = 1'b1;
        hazard_en = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over load-use: the FD instruction is squashed anyway.
    if (hazard_en) begin
      if (bus.branch_taken) begin
        flush_fd_c  = 1'b1;
        bubble_dx_c = 1'b1;
      end else if (load_use) begin
        stall_fd_c  = 1'b1;
        bubble_dx_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      tmo_q   <= tmo_d;
    end
  end

  // Combinational outputs are forced low while reset is held so nothing
  // reaches the pipe even if the IR inputs look like a hazard.
  assign bus.ctrl_mult       = ctrl_mult_c & reset_n;
  assign bus.ctrl_div        = ctrl_div_c  & reset_n;
  assign bus.stall_fd        = stall_fd_c  & reset_n;
  assign bus.stall_dx        = stall_dx_c  & reset_n;
  assign bus.bubble_dx       = bubble_dx_c & reset_n;
  assign bus.flush_fd        = flush_fd_c  & reset_n;
  assign bus.md_busy         = md_busy_c   & reset_n;
  assign bus.md_result_valid = valid_c     & reset_n;
  assign bus.md_exception    = exc_q & valid_c & reset_n;
  assign bus.md_result       = res_q;
  assign bus.md_timeout      = tmo_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  int   errors  = 0;
  int   checks  = 0;

  hazard_ctrl_if hif();
  hazard_ctrl #(.MD_TIMEOUT(40)) u_dut (.clock(clock), .reset_n(reset_n), .bus(hif.slave));

  initial forever #5 clock = ~clock;

  localparam logic [4:0] OP_LW = 5'b01000, OP_SW = 5'b00111, OP_BNE = 5'b00010;
  localparam logic [4:0] OP_BLT = 5'b00110, OP_JR = 5'b00100, OP_BEX = 5'b10110;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] ALU_ADD = 5'b00000, ALU_MUL = 5'b00110, ALU_DIV = 5'b00111;

  // Output vector order: ctrl_mult ctrl_div stall_fd stall_dx bubble_dx
  //                      flush_fd md_busy md_result_valid md_exception md_timeout
  localparam logic [9:0] O_NONE  = 10'b00_00_00_0_000;
  localparam logic [9:0] O_LU    = 10'b00_10_10_0_000;
  localparam logic [9:0] O_FLUSH = 10'b00_00_11_0_000;
  localparam logic [9:0] O_SMUL  = 10'b10_11_00_1_000;
  localparam logic [9:0] O_SDIV  = 10'b01_11_00_1_000;
  localparam logic [9:0] O_BUSY  = 10'b00_11_00_1_000;
  localparam logic [9:0] O_DONE  = 10'b00_00_00_0_100;
  localparam logic [9:0] O_DEXC  = 10'b00_00_00_0_110;
  localparam logic [9:0] O_TMO   = 10'b00_00_00_0_001;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, rs, rt, alu);
    return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [9:0] outs();
    return {hif.ctrl_mult, hif.ctrl_div, hif.stall_fd, hif.stall_dx, hif.bubble_dx,
            hif.flush_fd, hif.md_busy, hif.md_result_valid, hif.md_exception, hif.md_timeout};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    hif.fd_out_ir = '0; hif.dx_out_ir = '0; hif.branch_taken = 1'b0;
    hif.data_resultRDY = 1'b0; hif.data_result = '0; hif.data_exception = 1'b0;
    #3 reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs(), O_NONE);
    end
    checks++;
    if (hif.md_result !== 32'h0) begin
      errors++; $display("FAIL reset_md_result: got %h expected 0", hif.md_result);
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL reset_release: got %b expected %b", outs(), O_NONE);
    end
  endtask

  task automatic test_load_use();
    logic [31:0] dx_v[13];
    logic [31:0] fd_v[13];
    logic        st_v[13];
    dx_v[0]  = enc_i(OP_LW, 5, 2, 0);  fd_v[0]  = enc_r(7, 5, 3, ALU_ADD);   st_v[0]  = 1;
    dx_v[1]  = enc_i(OP_LW, 0, 2, 0);  fd_v[1]  = enc_r(7, 0, 3, ALU_ADD);   st_v[1]  = 0;
    dx_v[2]  = enc_i(OP_LW, 5, 2, 0);  fd_v[2]  = enc_r(7, 4, 3, ALU_ADD);   st_v[2]  = 0;
    dx_v[3]  = enc_i(OP_LW, 5, 2, 0);  fd_v[3]  = enc_r(7, 3, 5, ALU_ADD);   st_v[3]  = 1;
    dx_v[4]  = enc_i(OP_LW, 5, 2, 0);  fd_v[4]  = enc_i(OP_SW, 5, 2, 0);     st_v[4]  = 0;
    dx_v[5]  = enc_i(OP_LW, 5, 2, 0);  fd_v[5]  = enc_i(OP_SW, 6, 5, 0);     st_v[5]  = 1;
    dx_v[6]  = enc_i(OP_LW, 5, 2, 0);  fd_v[6]  = enc_i(OP_BNE, 5, 6, 4);    st_v[6]  = 1;
    dx_v[7]  = enc_i(OP_LW, 5, 2, 0);  fd_v[7]  = enc_i(OP_BLT, 6, 5, 4);    st_v[7]  = 1;
    dx_v[8]  = enc_i(OP_LW, 5, 2, 0);  fd_v[8]  = enc_i(OP_JR, 5, 0, 0);     st_v[8]  = 1;
    dx_v[9]  = enc_i(OP_LW, 30, 1, 0); fd_v[9]  = {OP_BEX, 27'd100};         st_v[9]  = 1;
    dx_v[10] = enc_i(OP_LW, 5, 2, 0);  fd_v[10] = enc_i(OP_ADDI, 7, 5, 1);   st_v[10] = 1;
    dx_v[11] = enc_i(OP_LW, 5, 2, 0);  fd_v[11] = enc_i(OP_ADDI, 5, 2, 1);   st_v[11] = 0;
    dx_v[12] = enc_r(5, 1, 2, ALU_ADD); fd_v[12] = enc_r(7, 5, 3, ALU_ADD);  st_v[12] = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      hif.dx_out_ir = dx_v[i];
      hif.fd_out_ir = fd_v[i];
      @(negedge clock);
      checks++;
      if (outs() !== (st_v[i] ? O_LU : O_NONE)) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, outs(), st_v[i] ? O_LU : O_NONE);
      end
      tick();
      hif.dx_out_ir = '0;
      @(negedge clock);
      checks++;
      if (outs() !== O_NONE) begin
        errors++; $display("FAIL load_use_release[%0d]: got %b expected %b", i, outs(), O_NONE);
      end
    end
  endtask

  task automatic test_flush();
    tick();
    hif.dx_out_ir    = enc_i(OP_LW, 5, 2, 0);
    hif.fd_out_ir    = enc_r(7, 5, 3, ALU_ADD);
    hif.branch_taken = 1'b1;
    @(negedge clock);
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++; $display("FAIL flush_over_load_use: got %b expected %b", outs(), O_FLUSH);
    end
    // A mul/div in DX while a taken branch is reported must not start.
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    hif.fd_out_ir = '0;
    @(negedge clock);
    checks++;
    if (outs() !== O_FLUSH) begin
      errors++; $display("FAIL flush_with_mul: got %b expected %b", outs(), O_FLUSH);
    end
    tick();
    hif.branch_taken = 1'b0;
    hif.dx_out_ir    = '0;
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL flush_no_start: got %b expected %b", outs(), O_NONE);
    end
  endtask

  task automatic test_mul();
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    hif.fd_out_ir = enc_r(9, 8, 8, ALU_ADD);
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL mul_idle: got %b expected %b", outs(), O_NONE);
    end
    tick();
    @(negedge clock);
    checks++;
    if (outs() !== O_SMUL) begin
      errors++; $display("FAIL mul_start: got %b expected %b", outs(), O_SMUL);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin
        hif.data_resultRDY = 1'b1;
        hif.data_result    = 32'h0000_0018;
      end
      @(negedge clock);
      checks++;
      if (outs() !== O_BUSY) begin
        errors++; $display("FAIL mul_busy[%0d]: got %b expected %b", i, outs(), O_BUSY);
      end
    end
    tick();
    hif.data_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== O_DONE) begin
      errors++; $display("FAIL mul_done: got %b expected %b", outs(), O_DONE);
    end
    checks++;
    if (hif.md_result !== 32'h0000_0018) begin
      errors++; $display("FAIL mul_result: got %h expected 00000018", hif.md_result);
    end
    tick();
    hif.dx_out_ir = '0;
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL mul_after: got %b expected %b", outs(), O_NONE);
    end
  endtask

  task automatic test_div_by_zero();
    int mult_seen = 0, div_seen = 0;
    tick();
    hif.dx_out_ir = enc_r(4, 2, 0, ALU_DIV);
    @(negedge clock);
    mult_seen += int'(hif.ctrl_mult); div_seen += int'(hif.ctrl_div);
    tick();
    @(negedge clock);
    checks++;
    if (outs() !== O_SDIV) begin
      errors++; $display("FAIL div_start: got %b expected %b", outs(), O_SDIV);
    end
    mult_seen += int'(hif.ctrl_mult); div_seen += int'(hif.ctrl_div);
    tick();
    hif.data_resultRDY = 1'b1;
    hif.data_result    = 32'h0;
    hif.data_exception = 1'b1;
    @(negedge clock);
    mult_seen += int'(hif.ctrl_mult); div_seen += int'(hif.ctrl_div);
    tick();
    hif.data_resultRDY = 1'b0;
    hif.data_exception = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== O_DEXC) begin
      errors++; $display("FAIL div_done_exc: got %b expected %b", outs(), O_DEXC);
    end
    mult_seen += int'(hif.ctrl_mult); div_seen += int'(hif.ctrl_div);
    tick();
    hif.dx_out_ir = '0;
    @(negedge clock);
    mult_seen += int'(hif.ctrl_mult); div_seen += int'(hif.ctrl_div);
    checks++;
    if (div_seen !== 1 || mult_seen !== 0) begin
      errors++; $display("FAIL div_pulses: got div=%0d mult=%0d expected div=1 mult=0", div_seen, mult_seen);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    tick();                                 // START
    hif.data_resultRDY = 1'b1;              // ignored outside BUSY
    hif.data_result    = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++;
    if (outs() !== O_SMUL) begin
      errors++; $display("FAIL b2b_start_rdy_ignored: got %b expected %b", outs(), O_SMUL);
    end
    tick();                                 // BUSY, RDY seen now
    hif.data_result = 32'h0000_0021;
    @(negedge clock);
    checks++;
    if (outs() !== O_BUSY) begin
      errors++; $display("FAIL b2b_busy: got %b expected %b", outs(), O_BUSY);
    end
    tick();                                 // DONE
    hif.data_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== O_DONE || hif.md_result !== 32'h0000_0021) begin
      errors++; $display("FAIL b2b_done1: got %b/%h expected %b/00000021", outs(), hif.md_result, O_DONE);
    end
    tick();                                 // IDLE, second mul enters DX
    hif.dx_out_ir = enc_r(6, 4, 4, ALU_MUL);
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL b2b_idle: got %b expected %b", outs(), O_NONE);
    end
    tick();
    @(negedge clock);
    checks++;
    if (outs() !== O_SMUL) begin
      errors++; $display("FAIL b2b_start2: got %b expected %b", outs(), O_SMUL);
    end
    tick();
    hif.data_resultRDY = 1'b1;
    hif.data_result    = 32'h0000_0441;
    tick();
    hif.data_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== O_DONE || hif.md_result !== 32'h0000_0441) begin
      errors++; $display("FAIL b2b_done2: got %b/%h expected %b/00000441", outs(), hif.md_result, O_DONE);
    end
    tick();
    hif.dx_out_ir = '0;
  endtask

  task automatic test_timeout();
    int  busy_cycles = 0;
    bit  done = 0;
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    tick();
    @(negedge clock);
    checks++;
    if (outs() !== O_SMUL) begin
      errors++; $display("FAIL tmo_start: got %b expected %b", outs(), O_SMUL);
    end
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      @(negedge clock);
      if (hif.md_result_valid) done = 1;
      else if (hif.md_busy) busy_cycles++;
    end
    checks++;
    if (!done || busy_cycles !== 40) begin
      errors++; $display("FAIL tmo_busy_cycles: got done=%0d busy=%0d expected done=1 busy=40", done, busy_cycles);
    end
    checks++;
    if (outs() !== (O_DEXC | O_TMO) || hif.md_result !== 32'h0) begin
      errors++; $display("FAIL tmo_done: got %b/%h expected %b/00000000", outs(), hif.md_result, O_DEXC | O_TMO);
    end
    tick();
    hif.dx_out_ir = '0;
    @(negedge clock);
    checks++;
    if (outs() !== O_TMO) begin
      errors++; $display("FAIL tmo_sticky_idle: got %b expected %b", outs(), O_TMO);
    end
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    tick();                                 // START
    tick();                                 // BUSY
    hif.data_resultRDY = 1'b1;
    hif.data_result    = 32'h0000_0055;
    tick();                                 // DONE
    hif.data_resultRDY = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== (O_DONE | O_TMO) || hif.md_result !== 32'h0000_0055) begin
      errors++; $display("FAIL tmo_sticky_next_op: got %b/%h expected %b/00000055", outs(), hif.md_result, O_DONE | O_TMO);
    end
    tick();
    hif.dx_out_ir = '0;
  endtask

  task automatic test_async_reset();
    tick();
    hif.dx_out_ir = enc_r(4, 2, 3, ALU_MUL);
    tick();                                 // START
    tick();                                 // BUSY, counter 0
    for (int i = 0; i < 10; i++) tick();    // counter 10
    @(negedge clock);
    checks++;
    if (outs() !== (O_BUSY | O_TMO)) begin
      errors++; $display("FAIL areset_pre_busy: got %b expected %b", outs(), O_BUSY | O_TMO);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== O_NONE || hif.md_result !== 32'h0) begin
      errors++; $display("FAIL areset_immediate: got %b/%h expected %b/00000000", outs(), hif.md_result, O_NONE);
    end
    hif.dx_out_ir = '0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (outs() !== O_NONE) begin
        errors++; $display("FAIL areset_release[%0d]: got %b expected %b", i, outs(), O_NONE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_mul();
    test_div_by_zero();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and multdiv sequencing controller for the 5-stage core: it handles the hazards that operand forwarding cannot resolve. Forwarding supplies operands that already exist in XM/MW. This block decides when the front of the pipe must wait or be squashed instead:
- load-use stalls
- taken-branch flushes
- multi-cycle mul/div, which freezes FD/DX until the multdiv unit finishes and then hands the result to the DX→XM path.

## Interface
Parameters:
- MD_TIMEOUT, 40, max BUSY cycles waited for data_resultRDY before aborting the operation

Ports:
- clock  in  1  single core clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- fd_out_ir  in  32  instruction in FD latch
- dx_out_ir  in  32  instruction in DX latch
- branch_taken  in  1  X stage resolved a taken branch/jump (from DX instruction)
- data_resultRDY  in  1  multdiv unit result ready
- data_result  in  32  multdiv result
- data_exception  in  1  multdiv exception (overflow / div-by-zero)
- ctrl_mult  out  1  one-cycle start pulse for multiply
- ctrl_div  out  1  one-cycle start pulse for divide
- stall_fd  out  1  hold PC and FD latch
- stall_dx  out  1  hold DX latch
- bubble_dx  out  1  load a nop (32'b0) into DX at next edge
- flush_fd  out  1  load a nop into FD at next edge
- md_busy  out  1  multdiv operation in flight (START or BUSY)
- md_result  out  32  latched multdiv result
- md_result_valid  out  1  md_result valid this cycle; XM input muxes md_result over ALU output
- md_exception  out  1  latched exception, qualified by md_result_valid
- md_timeout  out  1  sticky: a timeout has occurred since reset

## Operation
Decode fields:
- opcode [31:27]; R-type opcode 00000; ALU op [6:2].
- mul = R-type with ALU op 00110; div = R-type with ALU op 00111.
- lw 01000, sw 00111, bne 00010, blt 00110, jr 00100, bex 10110.

Registers read by the FD instruction (used for load-use):
- R-type: rs [21:17] and rt [16:12].
- sw, bne, blt: rs [21:17] and rd [26:22].
- jr: rd [26:22].
- bex: register 30.
- Other I-type: rs [21:17].

Load-use hazard:
- Condition: DX opcode is lw, DX rd [26:22] ≠ 0, and DX rd equals any FD read register.
- Response: stall_fd=1, bubble_dx=1 for exactly one cycle.
- Exception: FD sw whose only match is rd does not stall; that case is covered by the memory-stage forward.

Flush:
- branch_taken=1 → flush_fd=1 and bubble_dx=1; stall_fd=0.
- Flush overrides the load-use response.

Multdiv FSM (states IDLE, START, BUSY, DONE):
- IDLE:
  - If DX holds mul/div and branch_taken=0: go to START.
  - Otherwise apply the hazard/flush rules above.
- START (1 cycle):
  - ctrl_mult or ctrl_div =1 per DX op.
  - stall_fd=stall_dx=1; clear the cycle counter; go to BUSY.
- BUSY:
  - stall_fd=stall_dx=1; counter increments each cycle.
  - data_resultRDY=1 → latch data_result and data_exception; go to DONE.
  - Else counter==MD_TIMEOUT-1 → md_result=0, md_exception=1, md_timeout set; go to DONE.
- DONE (1 cycle):
  - md_result_valid=1, stalls released; mul/div advances to XM.
  - Load-use and flush rules are evaluated normally this cycle; go to IDLE.
  - The incoming DX instruction is examined next cycle, so back-to-back mul/div restarts cleanly.

General rules:
- Load-use detection is suppressed in START/BUSY; the stall already covers it.
- bubble_dx is never asserted in START/BUSY.
- data_resultRDY outside BUSY is ignored.
- md_busy=1 in START and BUSY.

## Timing
- Reset (reset_n low, any state):
  - All outputs 0; state IDLE; counter 0; md_result 0; md_timeout cleared.
  - Applies immediately, mid-operation included; an interrupted mul/div is not resumed.
- Stall/flush/bubble/ctrl outputs are combinational from state plus IR inputs, valid in the same cycle.
- md_result, md_exception and md_timeout are registered.
- mul/div occupying DX at cycle T:
  - START at T+1; BUSY from T+2.
  - If RDY is first seen in BUSY at cycle R, DONE is at R+1 and the instruction is in XM at R+2.
- Timeout: DONE is reached MD_TIMEOUT BUSY cycles after entering BUSY.
- Counter width ≥ clog2(MD_TIMEOUT)+1; it must not wrap before the timeout compare.

## Test plan
- Load-use: DX=lw $5,0($2), FD=add $7,$5,$3 → stall_fd=bubble_dx=1 for one cycle, then 0. Repeating with lw $0 or FD add $7,$4,$3 → no stall.
- Branch flush: branch_taken=1 with DX=lw $5 and FD reading $5 → flush_fd=1, bubble_dx=1, stall_fd=0.
- Multiply: DX=mul $4,$2,$3 → ctrl_mult pulses once; stalls held 1+N cycles; RDY with data_result=0x00000018 → DONE cycle shows md_result_valid=1, md_result=0x18, stalls 0.
- Divide by zero: div op, RDY with data_exception=1 → md_exception=1 with md_result_valid; ctrl_div one pulse and ctrl_mult never asserted.
- Timeout (MD_TIMEOUT=40, RDY held 0) → DONE after 40 BUSY cycles with md_result=0, md_exception=1; md_timeout stays 1 through later operations until reset.
- Async reset mid-BUSY (counter=10) → all outputs 0 immediately. Releasing reset_n with DX=nop → IDLE, no ctrl pulse.
